// File: rtl/textlcd_axi_slave.sv
// AXI4-Lite slave driving an HD44780-style character LCD.
// Four 32-bit registers (CMD, CHAR, CTRL, TIMING) sit behind a single-beat AXI4-Lite port.
// A CMD or CHAR write with CTRL[0]=1 launches one timed LCD write cycle:
// SETUP -> PULSE (E high) -> HOLD -> WAIT.
//
// Handshake semantics: a transfer on any channel happens on the rising edge where
// both VALID and READY are high.
// - AWREADY/WREADY are a one-cycle pulse. It is raised one cycle after AWVALID and
//   WVALID are both seen, and only while no response is pending and the write is
//   not stalled behind a busy LCD.
// - ARREADY is a one-cycle pulse, raised while no read response is pending.
// - BVALID and RVALID stay asserted, with stable payload, until the matching READY
//   is high.
module textlcd_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              lcd_e,
    output logic                              lcd_rs,
    output logic                              lcd_rw,
    output logic [7:0]                        lcd_data,
    output logic                              lcd_busy
);

    localparam logic [1:0] IDX_CMD  = 2'd0;
    localparam logic [1:0] IDX_CHAR = 2'd1;
    localparam logic [1:0] IDX_CTRL = 2'd2;
    localparam logic [1:0] IDX_TIM  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } lcd_state_t;

    logic [31:0] regs [4];
    logic        aw_ready_q;
    logic        b_valid_q;
    logic        ar_ready_q;
    logic        r_valid_q;
    logic [31:0] r_data_q;

    lcd_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] tim_q;
    logic        lcd_rs_q;
    logic [7:0]  lcd_data_q;

    logic [1:0]  wr_idx;
    logic [1:0]  rd_idx;
    logic        wr_stall;
    logic        wr_en;
    logic        launch;
    logic [7:0]  launch_byte;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx = S_AXI_AWADDR[3:2];
    assign rd_idx = S_AXI_ARADDR[3:2];

    // CMD/CHAR writes must wait for the LCD bus while it is busy and enabled.
    assign wr_stall = lcd_busy && regs[IDX_CTRL][0] && !wr_idx[1];

    // The register update happens on the edge the READY pulse is consumed.
    assign wr_en = aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID;

    // The byte sent to the LCD is the low write lane, zeroed if that lane is not strobed.
    assign launch_byte = S_AXI_WDATA[7:0] & {8{S_AXI_WSTRB[0]}};
    assign launch      = wr_en && !wr_idx[1] && regs[IDX_CTRL][0] && (state_q == S_IDLE);

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    // Write channel: accept pulse, register update and write response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
        end else begin
            aw_ready_q <= !aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID && !b_valid_q && !wr_stall;
            if (wr_en) begin
                regs[wr_idx] <= apply_strb(regs[wr_idx], S_AXI_WDATA, S_AXI_WSTRB);
                b_valid_q    <= 1'b1;
            end else if (b_valid_q && S_AXI_BREADY) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Read channel: accept pulse, then capture the register value before any same-edge write.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= 32'd0;
        end else begin
            ar_ready_q <= !ar_ready_q && S_AXI_ARVALID && !r_valid_q;
            if (ar_ready_q && S_AXI_ARVALID) begin
                r_valid_q <= 1'b1;
                r_data_q  <= regs[rd_idx];
            end else if (r_valid_q && S_AXI_RREADY) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    // Launch-time capture of the LCD bus values and the timing fields for this transfer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
            tim_q      <= 32'd0;
        end else if (launch) begin
            lcd_rs_q   <= (wr_idx == IDX_CHAR);
            lcd_data_q <= launch_byte;
            tim_q      <= regs[IDX_TIM];
        end
    end

    // LCD transfer FSM state and phase counter registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: each phase loads its field and leaves when the counter reaches zero,
    // so a field of N lasts N+1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_SETUP;
                    cnt_d   = {8'd0, regs[IDX_TIM][7:0]};
                end
            end
            S_SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_PULSE;
                    cnt_d   = {8'd0, tim_q[15:8]};
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                state_d = S_WAIT;
                cnt_d   = tim_q[31:16];
            end
            S_WAIT: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // E and busy decode straight from state, so an asynchronous reset clears them at once.
    assign lcd_e    = (state_q == S_PULSE);
    assign lcd_busy = (state_q != S_IDLE);
    assign lcd_rw   = 1'b0;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_data = lcd_data_q;

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_textlcd_axi_slave.sv
// Directed bench for textlcd_axi_slave: register access, LCD timing, stalls,
// backpressure and reset behaviour.
module tb_textlcd_axi_slave;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;
    logic        lcd_busy;

    int checks = 0;
    int errors = 0;

    // Monitor counters, only ever written by the monitor process.
    int       busy_cnt = 0;
    int       e_cnt    = 0;
    int       pre_cnt  = 0;
    int       e_rises  = 0;
    logic     e_prev   = 1'b0;
    logic     e_seen   = 1'b0;
    logic [7:0] e_data = 8'h00;
    logic       e_rs   = 1'b0;

    textlcd_axi_slave dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .lcd_e         (lcd_e),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_data      (lcd_data),
        .lcd_busy      (lcd_busy)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LCD bus monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (lcd_busy) busy_cnt++;
        if (lcd_e) e_cnt++;
        if (lcd_busy && !lcd_e && !e_seen) pre_cnt++;
        if (lcd_e && !e_prev) begin
            e_rises++;
            e_data = lcd_data;
            e_rs   = lcd_rs;
        end
        if (lcd_e) e_seen = 1'b1;
        if (!lcd_busy) e_seen = 1'b0;
        e_prev = lcd_e;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output int cyc, output logic busy_at_acc);
        bit got;
        got         = 1'b0;
        cyc         = 0;
        busy_at_acc = 1'b0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (awready) begin
                got         = 1'b1;
                busy_at_acc = lcd_busy;
                check("wready_with_awready", {31'd0, wready}, 32'd1);
            end
        end
        check("write_accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("write_bvalid", {31'd0, bvalid}, 32'd1);
        check("write_bresp", {30'd0, bresp}, 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output int cyc);
        bit got;
        got     = 1'b0;
        cyc     = 0;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (arready) got = 1'b1;
        end
        check("read_accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        cyc++;
        arvalid = 1'b0;
        check("read_rvalid", {31'd0, rvalid}, 32'd1);
        check("read_rresp", {30'd0, rresp}, 32'd0);
        data = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            if (!lcd_busy) done = 1'b1;
        end
        check("wait_idle", {31'd0, done}, 32'd1);
    endtask

    initial begin : stimulus
        int          cyc;
        int          cyc_r;
        logic        bz;
        logic [31:0] rd;
        int          b0, e0, p0, r0;
        bit          saw_e;

        rst_n   = 1'b0;
        awaddr  = 4'h0; awprot = 3'd0; awvalid = 1'b0;
        wdata   = 32'd0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr  = 4'h0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("rst_lcd_busy", {31'd0, lcd_busy}, 32'd0);
        check("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
        check("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Disabled readback: CTRL is 0 during the CMD/CHAR writes.
        r0 = e_rises;
        axi_write(4'h0, 32'd1, 4'hF, cyc, bz);
        axi_write(4'h4, 32'd2, 4'hF, cyc, bz);
        axi_write(4'h8, 32'd3, 4'hF, cyc, bz);
        axi_write(4'hC, 32'd4, 4'hF, cyc, bz);
        axi_read(4'h0, rd, cyc); check("rb_cmd", rd, 32'd1);
        axi_read(4'h4, rd, cyc); check("rb_char", rd, 32'd2);
        axi_read(4'h8, rd, cyc); check("rb_ctrl", rd, 32'd3);
        axi_read(4'hC, rd, cyc); check("rb_timing", rd, 32'd4);
        check("rb_no_e", e_rises - r0, 32'd0);

        // Single CMD transfer with TIMING = 0x0003_0201.
        axi_write(4'hC, 32'h0003_0201, 4'hF, cyc, bz);
        axi_write(4'h8, 32'd1, 4'hF, cyc, bz);
        b0 = busy_cnt; e0 = e_cnt; p0 = pre_cnt; r0 = e_rises;
        axi_write(4'h0, 32'h0000_0038, 4'hF, cyc, bz);
        wait_idle();
        check("tx_busy_cycles", busy_cnt - b0, 32'd10);
        check("tx_setup_cycles", pre_cnt - p0, 32'd2);
        check("tx_pulse_cycles", e_cnt - e0, 32'd3);
        check("tx_e_rises", e_rises - r0, 32'd1);
        check("tx_data", {24'd0, e_data}, 32'h38);
        check("tx_rs", {31'd0, e_rs}, 32'd0);
        check("tx_idle_data_held", {24'd0, lcd_data}, 32'h38);

        // Back-to-back CHAR writes: the second stalls until the LCD is idle.
        r0 = e_rises;
        axi_write(4'h4, 32'h0000_0041, 4'hF, cyc, bz);
        check("b2b_first_rs_data", {23'd0, lcd_rs, lcd_data}, 32'h141);
        axi_write(4'h4, 32'h0000_0042, 4'hF, cyc, bz);
        check("b2b_stalled", {31'd0, (cyc > 5)}, 32'd1);
        check("b2b_accept_when_idle", {31'd0, bz}, 32'd0);
        wait_idle();
        check("b2b_e_rises", e_rises - r0, 32'd2);
        check("b2b_second_data", {24'd0, e_data}, 32'h42);
        check("b2b_second_rs", {31'd0, e_rs}, 32'd1);

        // Read TIMING and clear CTRL during a transfer: no stall, no abort.
        b0 = busy_cnt; e0 = e_cnt; r0 = e_rises;
        axi_write(4'h0, 32'h0000_0001, 4'hF, cyc, bz);
        check("mid_busy", {31'd0, lcd_busy}, 32'd1);
        axi_read(4'hC, rd, cyc_r);
        check("mid_read_timing", rd, 32'h0003_0201);
        check("mid_read_fast", {31'd0, (cyc_r <= 3)}, 32'd1);
        axi_write(4'h8, 32'd0, 4'hF, cyc, bz);
        check("mid_write_fast", {31'd0, (cyc + 1 <= 3)}, 32'd1);
        check("mid_write_during_busy", {31'd0, bz}, 32'd1);
        wait_idle();
        check("mid_busy_cycles", busy_cnt - b0, 32'd10);
        check("mid_pulse_cycles", e_cnt - e0, 32'd3);
        check("mid_e_rises", e_rises - r0, 32'd1);

        // Byte strobes (CTRL is 0, so no transfer).
        r0 = e_rises;
        axi_write(4'h0, 32'hAABB_CCDD, 4'b0101, cyc, bz);
        axi_read(4'h0, rd, cyc);
        check("strb_cmd", rd, 32'h00BB_00DD);
        check("strb_no_e", e_rises - r0, 32'd0);

        // Write backpressure with a second write pending.
        awaddr = 4'hC; wdata = 32'h0005_0403; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        saw_e = 1'b0;
        for (int i = 0; i < 20 && !saw_e; i++) begin
            @(posedge clk); #1;
            if (awready) saw_e = 1'b1;
        end
        check("bp_w_accept", {31'd0, saw_e}, 32'd1);
        @(posedge clk); #1;
        awaddr = 4'h4; wdata = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
            check("bp_bresp_held", {30'd0, bresp}, 32'd0);
            check("bp_no_second_aw", {31'd0, awready}, 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bp_bvalid_dropped", {31'd0, bvalid}, 32'd0);

        // Read backpressure with arvalid kept high.
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        saw_e = 1'b0;
        for (int i = 0; i < 20 && !saw_e; i++) begin
            @(posedge clk); #1;
            if (arready) saw_e = 1'b1;
        end
        check("bp_r_accept", {31'd0, saw_e}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rvalid_held", {31'd0, rvalid}, 32'd1);
            check("bp_rdata_held", rdata, 32'h0005_0403);
            check("bp_no_second_ar", {31'd0, arready}, 32'd0);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("bp_rvalid_dropped", {31'd0, rvalid}, 32'd0);
        axi_read(4'h4, rd, cyc);
        check("bp_char_unchanged", rd, 32'h0000_0042);

        // Simultaneous read and write of TIMING: read sees the old value.
        fork
            axi_write(4'hC, 32'd0, 4'hF, cyc, bz);
            axi_read(4'hC, rd, cyc_r);
        join
        check("rw_same_cycle_old", rd, 32'h0005_0403);
        axi_read(4'hC, rd, cyc);
        check("rw_new_value", rd, 32'd0);

        // All-zero TIMING: every phase lasts exactly one cycle.
        axi_write(4'h8, 32'd1, 4'hF, cyc, bz);
        b0 = busy_cnt; e0 = e_cnt; r0 = e_rises;
        axi_write(4'h4, 32'h0000_007A, 4'hF, cyc, bz);
        wait_idle();
        check("zero_busy_cycles", busy_cnt - b0, 32'd4);
        check("zero_pulse_cycles", e_cnt - e0, 32'd1);
        check("zero_data", {23'd0, e_rs, e_data}, 32'h17A);

        // Reset during PULSE.
        axi_write(4'hC, 32'h0003_0201, 4'hF, cyc, bz);
        axi_write(4'h0, 32'h0000_0099, 4'hF, cyc, bz);
        saw_e = 1'b0;
        for (int i = 0; i < 20 && !saw_e; i++) begin
            if (lcd_e) saw_e = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rst_mid_saw_pulse", {31'd0, saw_e}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("rst_mid_busy", {31'd0, lcd_busy}, 32'd0);
        check("rst_mid_data", {24'd0, lcd_data}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(4'h0, rd, cyc); check("post_rst_cmd", rd, 32'd0);
        axi_read(4'h4, rd, cyc); check("post_rst_char", rd, 32'd0);
        axi_read(4'h8, rd, cyc); check("post_rst_ctrl", rd, 32'd0);
        axi_read(4'hC, rd, cyc); check("post_rst_timing", rd, 32'd0);
        check("post_rst_idle", {31'd0, lcd_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/textlcd_axi_slave.md
TEXTLCD_AXI_SLAVE -- requirements
Module: textlcd_axi_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4: AXI4-Lite byte address width; four 32-bit registers.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous and active-low.
REQ-005 S_AXI_AWADDR/AWPROT/AWVALID  in  4/3/1; S_AXI_AWREADY  out  1  write address channel; AWPROT ignored.
REQ-006 S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1  write data channel.
REQ-007 S_AXI_BRESP  out  2, S_AXI_BVALID  out  1, S_AXI_BREADY  in  1  write response channel.
REQ-008 S_AXI_ARADDR/ARPROT/ARVALID  in  4/3/1; S_AXI_ARREADY  out  1  read address channel; ARPROT ignored.
REQ-009 S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID  out  1, S_AXI_RREADY  in  1  read data channel.
REQ-010 lcd_e/lcd_rs/lcd_rw  out  1/1/1; lcd_data  out  8  HD44780-style character LCD bus, write-only.
REQ-011 lcd_busy  out  1  high while the LCD transfer FSM is not IDLE.

Function
REQ-012 Register map, decoded from address bits [3:2]: 0x0 CMD, 0x4 CHAR, 0x8 CTRL (bit0 = LCD enable), 0xC TIMING ([7:0] setup, [15:8] E-high, [31:16] post-wait).
REQ-013 All four registers shall be read/write; a read shall return the last value written, honoring WSTRB byte lanes.
REQ-014 Write accept: when AWVALID and WVALID are both high, BVALID is low, and the write is not stalled, AWREADY and WREADY shall pulse high together for one cycle, one cycle later.
REQ-015 Latch: the register update shall occur on the same edge that AWREADY and WREADY drop.
REQ-016 Write response: BVALID shall rise on that edge with BRESP=00, and shall hold until BREADY is high.
REQ-017 Only one write shall be outstanding; no new AW/W acceptance while BVALID=1.
REQ-018 Read accept: when ARVALID=1 and RVALID=0, ARREADY shall pulse for one cycle.
REQ-019 Read data: RVALID shall rise on the next edge with RDATA=register[ARADDR[3:2]] and RRESP=00, and shall hold until RREADY is high.
REQ-020 A read and a write in the same cycle shall both proceed; RDATA shall return the pre-write value.
REQ-021 Launch: a write to CMD (rs=0) or CHAR (rs=1) with CTRL[0]=1 shall launch an LCD transfer of WDATA[7:0], masked by WSTRB[0].
REQ-022 A CMD/CHAR write with CTRL[0]=0 shall update the register and shall not launch a transfer.
REQ-023 Stall: while lcd_busy=1 and CTRL[0]=1, an AW/W pair addressed to CMD or CHAR shall be stalled (AWREADY/WREADY held low) until the FSM returns to IDLE; writes to CTRL/TIMING and all reads shall not stall.
REQ-024 FSM states IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE.
REQ-025 SETUP lasts TIMING[7:0]+1 cycles, with lcd_rs and lcd_data driven and lcd_e=0.
REQ-026 PULSE lasts TIMING[15:8]+1 cycles with lcd_e=1.
REQ-027 HOLD lasts 1 cycle with lcd_e=0, data and rs unchanged.
REQ-028 WAIT lasts TIMING[31:16]+1 cycles.
REQ-029 TIMING shall be sampled at launch; writes to TIMING mid-transfer shall not affect the current transfer.
REQ-030 The phase counter shall be 16 bits; a field value of 0 yields exactly 1 cycle (no wrap or underflow).
REQ-031 lcd_rw shall be constant 0; lcd_data/lcd_rs shall hold their last value in IDLE.
REQ-032 Clearing CTRL[0] mid-transfer shall not abort the current transfer.

Reset
REQ-033 ARESETN=0 shall asynchronously force: all registers to 0, FSM to IDLE, all READY/VALID outputs to 0, BRESP/RRESP/RDATA to 0, lcd_e/lcd_rs/lcd_rw/lcd_busy to 0, lcd_data to 0x00.
REQ-034 Reset asserted mid-transfer or mid-handshake shall abandon it; after release, the first accepted write shall behave as from power-up.

Verification
REQ-035 Disabled readback: after reset, write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read all four -> reads return 1,2,3,4, all RRESP=00, and lcd_e never rises because CTRL was 0 during the CMD/CHAR writes.
REQ-036 Single transfer: TIMING=0x0003_0201, CTRL=1, write 0x38 to CMD -> lcd_rs=0 and lcd_data=0x38, with 2 SETUP, 3 PULSE (lcd_e=1), 1 HOLD and 4 WAIT cycles; lcd_busy high for exactly 10 cycles.
REQ-037 Back-to-back stall: CTRL=1, write 0x41 to CHAR, then immediately write 0x42 to CHAR -> AWREADY for the second write is held low until lcd_busy falls, after which a second PULSE occurs with lcd_rs=1 and lcd_data=0x42.
REQ-038 Non-stalling access during transfer: a read of TIMING and a write to CTRL during a transfer complete within 3 cycles, with no stall.
REQ-039 Backpressure: BREADY/RREADY held low for 5 cycles -> BVALID/RVALID and their data remain stable, and no second write or read is accepted.
REQ-040 Reset mid-transfer: ARESETN=0 during PULSE -> lcd_e=0 and lcd_busy=0 immediately (before the next clock edge), and all registers read 0 after release.
